// File: rtl/inst_fetch_pkg.sv
// Shared widths, chip-enable encodings and the fetch queue entry layout
// used by the instruction fetch stage.
package inst_fetch_pkg;

    localparam int INST_ADDR_W       = 32;
    localparam int INST_W            = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;

    localparam logic              CHIP_ENABLE  = 1'b1;
    localparam logic              CHIP_DISABLE = 1'b0;
    localparam logic [INST_W-1:0] ZERO_WORD    = '0;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, inst} entries with a synchronous clear that
// overrides push and pop; only the pointers and count are reset.
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = FETCH_QUEUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  fetch_entry_t       wdata,
    output fetch_entry_t       rdata,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count masks stale entries and
    // leaving it out of reset lets the array map onto plain RAM/flops without a reset net.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[tail_q] <= wdata;
    end

    assign rdata = mem_q[head_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the fetch PC, drives the combinational ROM and buffers
// returned (pc, inst) pairs toward IF/ID through a valid/ready handshake.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                     DEPTH    = FETCH_QUEUE_DEPTH,
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce,
    output logic [INST_ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0]      rom_inst,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    input  logic                   flush_i,
    input  logic [INST_ADDR_W-1:0] new_pc_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INST_ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0]      out_inst
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic                   ce_q, ce_d;

    logic             pop, redirect, can_push, push;
    logic             q_full, q_empty;
    logic [CNT_W-1:0] q_count;
    fetch_entry_t     q_wdata, q_rdata;

    assign pop      = out_valid & out_ready;
    assign redirect = flush_i | branch_flag_i;
    assign can_push = ~q_full | pop;
    assign push     = ce_q & can_push & ~redirect;

    assign rom_ce   = push ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr = fetch_pc_q;
    assign q_wdata  = '{pc: fetch_pc_q, inst: rom_inst};

    always_comb begin
        ce_d       = 1'b1;
        fetch_pc_d = fetch_pc_q;
        // Flush outranks branch; both take a one-cycle bubble with no push.
        if (flush_i)            fetch_pc_d = word_align(new_pc_i);
        else if (branch_flag_i) fetch_pc_d = word_align(branch_target_i);
        else if (push)          fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            ce_q       <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ce_q       <= ce_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Mask the head slot when empty so stale storage never reaches IF/ID.
    assign out_valid = ~q_empty;
    assign out_pc    = q_empty ? '0 : q_rdata.pc;
    assign out_inst  = q_empty ? ZERO_WORD : q_rdata.inst;

    logic unused_ok;
    assign unused_ok = ^q_count;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage that sits directly upstream of the combinational instruction ROM and downstream of the branch/exception logic.
- Owns the fetch PC and drives ROM chip-enable and address.
- Captures each returned instruction with its PC into a small queue.
- Presents (pc, inst) pairs to the IF/ID register through a valid/ready handshake, so decode stalls do not stop the ROM from prefetching into free slots.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- rom_ce  output  1  ROM chip enable, `ChipEnable/`ChipDisable.
- rom_addr  output  32 (`InstAddrBus)  byte address to ROM.
- rom_inst  input  32 (`InstBus)  ROM data, valid in the same cycle as rom_addr.
- branch_flag_i  input  1  redirect request from the branch unit.
- branch_target_i  input  32  redirect target.
- flush_i  input  1  exception flush request.
- new_pc_i  input  32  exception handler address.
- out_valid  output  1  queue head is valid.
- out_ready  input  1  IF/ID accepts the head this cycle.
- out_pc  output  32  head PC.
- out_inst  output  32  head instruction.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC, ce_q=0, queue empty (head=tail=count=0).
  - Outputs: rom_ce=`ChipDisable, rom_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=`ZeroWord.
- ce_q sets to 1 on the first clock after rst deasserts. The first fetch of RESET_PC therefore occurs in cycle 1 after reset release, not cycle 0.
- Signals, per cycle:
  - pop = out_valid & out_ready.
  - redirect = flush_i | branch_flag_i.
  - can_push = (count < DEPTH) | pop.
  - rom_ce = ce_q & can_push & ~redirect.
  - rom_addr = fetch_pc at all times.
- Push: when rom_ce=1, {fetch_pc, rom_inst} is written at tail on the clock edge and fetch_pc <= fetch_pc+4. The add wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- Pop: head advances on the clock edge.
  - Push and pop in the same cycle leaves count unchanged; this is legal at full and at empty.
  - At empty with push+pop in the same cycle, the popped entry is the old head. There is no bypass, because out_valid=0 at empty and no pop can occur.
- Redirect (registered, 1-cycle penalty):
  - On the clock edge, the queue is cleared (count=0, head=tail=0).
  - fetch_pc <= flush_i ? new_pc_i : branch_target_i, with bits[1:0] forced to 0.
  - No push occurs in the redirect cycle.
  - A pop in the redirect cycle still completes toward IF/ID, because the head was already presented. The queue state after the edge is empty regardless of the pop.
- Priority: rst > flush_i > branch_flag_i > push/pop.
- Full (count=DEPTH, out_ready=0): rom_ce=0, fetch_pc holds, contents hold.
- Empty: out_valid=0, out_pc=0, out_inst=`ZeroWord. The stale head value must not be exposed.
- Counter width: count is $clog2(DEPTH)+1 bits. head and tail are $clog2(DEPTH) bits and wrap naturally.
- Outputs out_* are driven combinationally from queue storage. No combinational path exists from out_ready to out_valid.

Decomposition:
- In define.v: `InstAddrBus, `InstBus, `ChipEnable/`ChipDisable, `ZeroWord, and a new `FetchQueueDepth default.
- One sub-module, fetch_queue:
  - Parameterised synchronous FIFO with push, pop, clear, full, empty, and count.
  - 64-bit {pc, inst} entries.
  - Async active-low reset on pointers only.
- inst_fetch holds the PC register, ce_q, and redirect/priority logic.

Test Plan:
- Release reset with out_ready=1 and ROM[i]=i → cycle 0 rom_ce=0; from cycle 1, rom_addr=0,4,8…; out_pc/out_inst follow 0/0, 4/1, 8/2 one cycle later; out_valid continuous.
- Hold out_ready=0 → exactly 4 pushes (pc 0..C); then rom_ce=0 and rom_addr=0x10 held. Raise out_ready → pop and push in the same cycle, count stays 4, next push is pc 0x10.
- branch_flag_i=1, target=0x100 with 3 entries queued → next cycle out_valid=0, rom_addr=0x100. The following cycle, out_pc=0x100.
- flush_i=1 (new_pc=0x180) and branch_flag_i=1 (target=0x200) in the same cycle → fetch resumes at 0x180.
- branch_target_i=0x203 → fetch_pc=0x200.
- Wrap: RESET_PC=32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst mid-stream with a full queue → out_valid=0 and rom_ce=0 immediately (async); after release, restart from RESET_PC.
